// File: rtl/gearbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_pkg
// Purpose  : Shared constants and helpers for the 64B/66B gearboxes.
//            AURORA_BLOCK_W is the block width. SYNC_DATA and SYNC_CTRL are
//            the sync header values. fill_w() sizes a fill counter so that it
//            can hold 0..BUF_W, where BUF_W = in_w + out_w - 1.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gearbox_pkg;

  localparam int         AURORA_BLOCK_W = 66;
  localparam logic [1:0] SYNC_DATA      = 2'b01;
  localparam logic [1:0] SYNC_CTRL      = 2'b10;

  // The counter must represent BUF_W itself, so it needs
  // clog2(BUF_W + 1) = clog2(in_w + out_w) bits.
  function automatic int fill_w(input int in_w, input int out_w);
    return $clog2(in_w + out_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_insert.sv
`default_nettype none
// ============================================================================
// Module   : bit_insert
// Purpose  : Combinational variable-offset OR-insert. word is zero-extended
//            to BUF_W, shifted left by pos and OR-ed into base. The caller
//            guarantees that the bits of base at and above pos are zero.
//            The RX gearbox reuses this block.
// Ports    : base   [BUF_W-1:0]  existing LSB-aligned bit buffer
//            word   [IN_W-1:0]   word to insert
//            pos    [POS_W-1:0]  insert offset (current fill level)
//            en                  insert enable; when low, result = base
//            result [BUF_W-1:0]  merged buffer
// Revision : 1.0 - initial release
// ============================================================================
module bit_insert
  import gearbox_pkg::*;
#(
  parameter int IN_W  = AURORA_BLOCK_W,
  parameter int BUF_W = 97,
  parameter int POS_W = fill_w(IN_W, BUF_W - IN_W + 1)
) (
  input  logic [BUF_W-1:0] base,
  input  logic [IN_W-1:0]  word,
  input  logic [POS_W-1:0] pos,
  input  logic             en,
  output logic [BUF_W-1:0] result
);

  logic [BUF_W-1:0] word_ext;

  always_comb begin
    word_ext             = '0;
    word_ext[IN_W-1:0]   = word;
    result               = base;
    if (en) begin
      // Bits shifted past BUF_W are dropped. The caller only inserts while
      // pos + IN_W <= BUF_W, so no data bits are lost here.
      result = base | (word_ext << pos);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gearbox_66_to_n.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_66_to_n
// Purpose  : Fill-level TX gearbox. It packs IN_W-bit 64B/66B blocks into
//            OUT_W-bit serdes words, LSB first, with valid/ready on both
//            sides. It also reports underflow when the serializer is starved.
// Ports    : clk                 sole clock
//            rst                 synchronous active-high reset
//            data_in  [IN_W-1:0] input block, sync header in [1:0]
//            in_valid            data_in valid
//            in_ready            block accepted this cycle (if in_valid)
//            data_out [OUT_W-1:0] output word
//            out_valid           data_out valid
//            out_ready           serializer consumes data_out
//            underflow           one-cycle pulse: word wanted, none ready
// Revision : 1.0 - initial release
// ============================================================================
module gearbox_66_to_n
  import gearbox_pkg::*;
#(
  parameter int IN_W  = AURORA_BLOCK_W,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             underflow
);

  localparam int                BUF_W   = IN_W + OUT_W - 1;
  localparam int                FILL_W  = fill_w(IN_W, OUT_W);
  localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  logic [BUF_W-1:0]  bit_buf;
  logic [BUF_W-1:0]  combined;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] avail;
  logic              accept;
  logic              emit;
  logic              primed;

  // in_ready depends only on registered state and rst, never on in_valid.
  // A block is taken only while fewer than OUT_W bits are buffered. That
  // keeps fill + IN_W <= BUF_W.
  assign in_ready = ~rst & (fill < OUT_W_F);
  assign accept   = in_valid & in_ready;
  assign avail    = fill + (accept ? IN_W_F : '0);
  // The output register can load when it is empty or is being drained
  // in this same cycle.
  assign emit     = (avail >= OUT_W_F) & (~out_valid | out_ready);

  bit_insert #(
    .IN_W  (IN_W),
    .BUF_W (BUF_W),
    .POS_W (FILL_W)
  ) u_insert (
    .base   (bit_buf),
    .word   (data_in),
    .pos    (fill),
    .en     (accept),
    .result (combined)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf   <= '0;
      fill      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      underflow <= 1'b0;
      primed    <= 1'b0;
    end else begin
      if (emit) begin
        data_out <= combined[OUT_W-1:0];
        // The logical shift zero-fills from the top. This keeps every bit
        // at or above fill cleared.
        bit_buf  <= combined >> OUT_W;
        fill     <= avail - OUT_W_F;
        primed   <= 1'b1;
      end else begin
        bit_buf  <= combined;
        fill     <= avail;
      end
      out_valid <= emit | (out_valid & ~out_ready);
      // primed keeps the idle period between reset and the first word from
      // being reported as underflow.
      underflow <= primed & out_ready & ~emit;
    end
  end

endmodule
`default_nettype wire
